issue_ctrl: RTL and testbench

- In-order issue scheduler between the instruction decoder and the execution unit (ALU/MUL/DIV).
- Holds one decoded instruction and tracks pending register writes in a 32-entry scoreboard.
- Issues when operands are free, the writeback port is free at the completion cycle, and the non-pipelined divider is idle.
- Reports writebacks and counts stall cycles.

---
 rtl/issue_ctrl_if.sv | 34 +++
 rtl/issue_ctrl.sv | 150 +++++++++++++++
 tb/tb_issue_ctrl.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/issue_ctrl_if.sv
// Decoder / execution-unit / writeback bundle around the issue controller.
interface issue_ctrl_if;
    logic        flush;
    logic        dec_valid;
    logic        dec_ready;
    logic [4:0]  dec_rd;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [3:0]  dec_alu_op;
    logic        dec_reg_write;
    logic        ex_valid;
    logic [3:0]  ex_alu_op;
    logic [4:0]  ex_rd;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] busy_vec;
    logic [15:0] stall_cnt;

    // Decoder side: presents instructions and observes issue/writeback.
    modport master (
        output flush, dec_valid, dec_rd, dec_rs1, dec_rs2, dec_alu_op, dec_reg_write,
        input  dec_ready, ex_valid, ex_alu_op, ex_rd, ex_rs1, ex_rs2,
        input  wb_valid, wb_rd, busy_vec, stall_cnt
    );

    // Controller side.
    modport slave (
        input  flush, dec_valid, dec_rd, dec_rs1, dec_rs2, dec_alu_op, dec_reg_write,
        output dec_ready, ex_valid, ex_alu_op, ex_rd, ex_rs1, ex_rs2,
        output wb_valid, wb_rd, busy_vec, stall_cnt
    );
endinterface

// File: rtl/issue_ctrl.sv
// In-order issue controller: one-entry hold slot, 32-entry register scoreboard,
// writeback reservation shift register and a non-pipelined divider interlock.
module issue_ctrl #(
    parameter int unsigned LAT_ALU  = 1,
    parameter int unsigned LAT_MUL  = 3,
    parameter int unsigned LAT_DIV  = 8,
    parameter int unsigned WB_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    issue_ctrl_if.slave bus
);
    localparam int unsigned REG_W    = 5;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned OP_W     = 4;
    localparam int unsigned LAT_W    = $clog2(WB_DEPTH + 1);
    localparam int unsigned DIV_W    = $clog2(LAT_DIV + 1);
    localparam int unsigned STALL_W  = 16;

    localparam logic [OP_W-1:0] OP_MUL = 4'b0011;
    localparam logic [OP_W-1:0] OP_DIV = 4'b0100;

    typedef struct packed {
        logic [OP_W-1:0]  alu_op;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic             reg_write;
    } instr_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
    } resv_t;

    logic                      hold_valid;
    instr_t                    hold;
    resv_t [WB_DEPTH-1:0]      res;
    resv_t [WB_DEPTH-1:0]      res_nxt;
    logic [NUM_REGS-1:0]       busy;
    logic [NUM_REGS-1:0]       busy_nxt;
    logic [DIV_W-1:0]          div_cnt;
    logic [STALL_W-1:0]        stall_cnt;
    logic [LAT_W-1:0]          lat;
    logic                      is_div;
    logic                      writes_rd;
    logic                      res_free;
    logic                      issue;
    logic                      dec_ready;
    logic                      accept;

    // Latency class of the held instruction; unknown codes behave as ALU.
    always_comb begin
        is_div = (hold.alu_op == OP_DIV);
        if (hold.alu_op == OP_MUL) begin
            lat = LAT_W'(LAT_MUL);
        end else if (is_div) begin
            lat = LAT_W'(LAT_DIV);
        end else begin
            lat = LAT_W'(LAT_ALU);
        end
    end

    // The entry now in slot lat is what lands in slot lat-1 next cycle,
    // i.e. it owns the writeback port at issue_cycle + lat.
    always_comb begin
        res_free = 1'b1;
        for (int unsigned i = 1; i < WB_DEPTH; i++) begin
            if (lat == LAT_W'(i) && res[i].valid) begin
                res_free = 1'b0;
            end
        end
    end

    // Issue decision from registered state only.
    always_comb begin
        writes_rd = hold.reg_write && (hold.rd != '0);
        issue     = hold_valid && !bus.flush
                 && !busy[hold.rs1] && !busy[hold.rs2]
                 && (!writes_rd || !busy[hold.rd])
                 && (!hold.reg_write || res_free)
                 && (!is_div || (div_cnt == '0));
        dec_ready = !bus.flush && (!hold_valid || issue);
        accept    = bus.dec_valid && dec_ready;
    end

    // Next reservation shift and scoreboard contents.
    always_comb begin
        res_nxt = '0;
        for (int unsigned i = 0; i + 1 < WB_DEPTH; i++) begin
            res_nxt[i] = res[i + 1];
        end
        for (int unsigned i = 0; i < WB_DEPTH; i++) begin
            if (issue && hold.reg_write && lat == LAT_W'(i + 1)) begin
                res_nxt[i] = '{valid: 1'b1, rd: hold.rd};
            end
        end
        busy_nxt = busy;
        if (res[0].valid) begin
            busy_nxt[res[0].rd] = 1'b0;
        end
        if (issue && writes_rd) begin
            busy_nxt[hold.rd] = 1'b1;
        end
    end

    // State update: hold slot, reservations, scoreboard, divider and stall counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_valid <= 1'b0;
            hold       <= '0;
            res        <= '0;
            busy       <= '0;
            div_cnt    <= '0;
            stall_cnt  <= '0;
        end else begin
            if (accept) begin
                hold_valid <= 1'b1;
                hold       <= '{alu_op:    bus.dec_alu_op,
                                rd:        bus.dec_rd,
                                rs1:       bus.dec_rs1,
                                rs2:       bus.dec_rs2,
                                reg_write: bus.dec_reg_write};
            end else if (issue || bus.flush) begin
                hold_valid <= 1'b0;
            end
            res  <= res_nxt;
            busy <= busy_nxt;
            if (issue && is_div) begin
                div_cnt <= DIV_W'(LAT_DIV - 1);
            end else if (div_cnt != '0) begin
                div_cnt <= div_cnt - DIV_W'(1);
            end
            if (hold_valid && !issue && !bus.flush && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + STALL_W'(1);
            end
        end
    end

    assign bus.dec_ready = dec_ready;
    assign bus.ex_valid  = issue;
    assign bus.ex_alu_op = hold.alu_op;
    assign bus.ex_rd     = hold.rd;
    assign bus.ex_rs1    = hold.rs1;
    assign bus.ex_rs2    = hold.rs2;
    assign bus.wb_valid  = res[0].valid;
    assign bus.wb_rd     = res[0].rd;
    assign bus.busy_vec  = busy;
    assign bus.stall_cnt = stall_cnt;
endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: directed timing scenarios plus randomized traffic
// checked against an absolute-time reference model.
module tb_issue_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    issue_ctrl_if bus ();

    issue_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int         at;
        logic [3:0] op;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rw;
    } req_t;

    req_t        q[$];
    logic        log_ex    [64];
    logic [3:0]  log_ex_op [64];
    logic [4:0]  log_ex_rd [64];
    logic        log_wb    [64];
    logic [4:0]  log_wb_rd [64];
    logic        log_rdy   [64];
    logic [31:0] log_busy  [64];
    logic [15:0] log_stall [64];

    // Reference model state: absolute cycle numbers of every hazard.
    int m_free_at  [32];
    int m_busy_from[32];
    int m_wb_at    [int];
    int m_div_free;

    task automatic idle_inputs;
        bus.flush = 1'b0;
        bus.dec_valid = 1'b0;
        bus.dec_rd = '0;
        bus.dec_rs1 = '0;
        bus.dec_rs2 = '0;
        bus.dec_alu_op = '0;
        bus.dec_reg_write = 1'b0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Offers queued requests in order and logs what the DUT does each cycle.
    task automatic run_seq(input int n, input int flush_k);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (q.size() != 0 && k >= q[0].at) begin
                bus.dec_valid = 1'b1;
                bus.dec_alu_op = q[0].op;
                bus.dec_rd = q[0].rd;
                bus.dec_rs1 = q[0].rs1;
                bus.dec_rs2 = q[0].rs2;
                bus.dec_reg_write = q[0].rw;
            end else begin
                bus.dec_valid = 1'b0;
            end
            bus.flush = (k == flush_k);
            #1;
            log_ex[k] = bus.ex_valid;
            log_ex_op[k] = bus.ex_alu_op;
            log_ex_rd[k] = bus.ex_rd;
            log_wb[k] = bus.wb_valid;
            log_wb_rd[k] = bus.wb_rd;
            log_rdy[k] = bus.dec_ready;
            log_busy[k] = bus.busy_vec;
            log_stall[k] = bus.stall_cnt;
            if (bus.dec_valid && bus.dec_ready) q.delete(0);
        end
    endtask

    task automatic test_reset;
        idle_inputs();
        #1;
        total++;
        if (bus.dec_ready !== 1'b1 || bus.ex_valid !== 1'b0 || bus.wb_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_held: ready=%b ex=%b wb=%b, want 1 0 0", bus.dec_ready, bus.ex_valid, bus.wb_valid);
        end
        do_reset();
        #1;
        total++;
        if (bus.dec_ready !== 1'b1 || bus.ex_valid !== 1'b0 || bus.wb_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: ready=%b ex=%b wb=%b, want 1 0 0", bus.dec_ready, bus.ex_valid, bus.wb_valid);
        end
        total++;
        if (bus.busy_vec !== 32'h0 || bus.stall_cnt !== 16'h0) begin
            bad++;
            $display("FAIL reset_state: busy=%h stall=%0d, want 0 0", bus.busy_vec, bus.stall_cnt);
        end
    endtask

    // add x3,x1,x2 then dependent add x4,x3,x5.
    task automatic test_raw;
        do_reset();
        q.delete();
        q.push_back('{4, 4'b0000, 5'd3, 5'd1, 5'd2, 1'b1});
        q.push_back('{4, 4'b0000, 5'd4, 5'd3, 5'd5, 1'b1});
        run_seq(12, -1);
        total++;
        if (log_ex[5] !== 1'b1 || log_ex_rd[5] !== 5'd3) begin
            bad++;
            $display("FAIL raw_issue1: ex=%b rd=%0d at 5, want 1/3", log_ex[5], log_ex_rd[5]);
        end
        total++;
        if (log_wb[6] !== 1'b1 || log_wb_rd[6] !== 5'd3 || log_ex[6] !== 1'b0) begin
            bad++;
            $display("FAIL raw_wb: wb=%b rd=%0d ex=%b at 6, want 1/3/0", log_wb[6], log_wb_rd[6], log_ex[6]);
        end
        total++;
        if (log_ex[7] !== 1'b1 || log_ex_rd[7] !== 5'd4) begin
            bad++;
            $display("FAIL raw_issue2: ex=%b rd=%0d at 7, want 1/4", log_ex[7], log_ex_rd[7]);
        end
        total++;
        if (log_busy[6] !== 32'h8 || log_busy[8] !== 32'h10) begin
            bad++;
            $display("FAIL raw_busy: %h %h, want 00000008 00000010", log_busy[6], log_busy[8]);
        end
        total++;
        if (log_stall[11] !== 16'd1 || log_wb[8] !== 1'b1 || log_wb_rd[8] !== 5'd4) begin
            bad++;
            $display("FAIL raw_stall: stall=%0d wb=%b rd=%0d, want 1/1/4", log_stall[11], log_wb[8], log_wb_rd[8]);
        end
    endtask

    // mul x5 then independent add x6 overtakes its writeback.
    task automatic test_mul_indep;
        do_reset();
        q.delete();
        q.push_back('{9, 4'b0011, 5'd5, 5'd1, 5'd2, 1'b1});
        q.push_back('{9, 4'b0000, 5'd6, 5'd1, 5'd2, 1'b1});
        run_seq(16, -1);
        total++;
        if (log_ex[10] !== 1'b1 || log_ex_op[10] !== 4'b0011 || log_ex_rd[10] !== 5'd5) begin
            bad++;
            $display("FAIL mul_issue: ex=%b op=%h rd=%0d at 10, want 1/3/5", log_ex[10], log_ex_op[10], log_ex_rd[10]);
        end
        total++;
        if (log_ex[11] !== 1'b1 || log_ex_rd[11] !== 5'd6 || log_busy[11] !== 32'h20) begin
            bad++;
            $display("FAIL mul_add_issue: ex=%b rd=%0d busy=%h at 11, want 1/6/00000020", log_ex[11], log_ex_rd[11], log_busy[11]);
        end
        total++;
        if (log_wb[12] !== 1'b1 || log_wb_rd[12] !== 5'd6 || log_wb[13] !== 1'b1 || log_wb_rd[13] !== 5'd5) begin
            bad++;
            $display("FAIL mul_wb_order: 12:%b/%0d 13:%b/%0d, want 1/6 1/5", log_wb[12], log_wb_rd[12], log_wb[13], log_wb_rd[13]);
        end
        total++;
        if (log_stall[15] !== 16'd0 || log_busy[14] !== 32'h0) begin
            bad++;
            $display("FAIL mul_idle: stall=%0d busy=%h, want 0 0", log_stall[15], log_busy[14]);
        end
    endtask

    // ALU op held at 12 would collide with the mul writeback at 13.
    task automatic test_wb_collision;
        do_reset();
        q.delete();
        q.push_back('{9, 4'b0011, 5'd5, 5'd1, 5'd2, 1'b1});
        q.push_back('{11, 4'b0001, 5'd6, 5'd1, 5'd2, 1'b1});
        run_seq(16, -1);
        total++;
        if (log_ex[12] !== 1'b0 || log_ex[13] !== 1'b1 || log_ex_rd[13] !== 5'd6) begin
            bad++;
            $display("FAIL coll_issue: ex12=%b ex13=%b rd=%0d, want 0/1/6", log_ex[12], log_ex[13], log_ex_rd[13]);
        end
        total++;
        if (log_wb_rd[13] !== 5'd5 || log_wb[14] !== 1'b1 || log_wb_rd[14] !== 5'd6) begin
            bad++;
            $display("FAIL coll_wb: rd13=%0d wb14=%b rd14=%0d, want 5/1/6", log_wb_rd[13], log_wb[14], log_wb_rd[14]);
        end
        total++;
        if (log_stall[15] !== 16'd1) begin
            bad++;
            $display("FAIL coll_stall: stall=%0d, want 1", log_stall[15]);
        end
    endtask

    // Two independent divides serialize on the divider.
    task automatic test_div;
        int early;
        int wb_mid;
        do_reset();
        q.delete();
        q.push_back('{19, 4'b0100, 5'd7, 5'd1, 5'd2, 1'b1});
        q.push_back('{19, 4'b0100, 5'd8, 5'd1, 5'd2, 1'b1});
        run_seq(40, -1);
        early = 0;
        wb_mid = 0;
        for (int k = 21; k < 28; k++) if (log_ex[k] === 1'b1) early++;
        for (int k = 29; k < 36; k++) if (log_wb[k] === 1'b1) wb_mid++;
        total++;
        if (log_ex[20] !== 1'b1 || log_ex_rd[20] !== 5'd7 || early != 0) begin
            bad++;
            $display("FAIL div_first: ex20=%b rd=%0d early=%0d, want 1/7/0", log_ex[20], log_ex_rd[20], early);
        end
        total++;
        if (log_ex[28] !== 1'b1 || log_ex_rd[28] !== 5'd8) begin
            bad++;
            $display("FAIL div_second: ex28=%b rd=%0d, want 1/8", log_ex[28], log_ex_rd[28]);
        end
        total++;
        if (log_wb[28] !== 1'b1 || log_wb_rd[28] !== 5'd7 || log_wb[36] !== 1'b1 || log_wb_rd[36] !== 5'd8 || wb_mid != 0) begin
            bad++;
            $display("FAIL div_wb: 28:%b/%0d 36:%b/%0d mid=%0d, want 1/7 1/8 0", log_wb[28], log_wb_rd[28], log_wb[36], log_wb_rd[36], wb_mid);
        end
        total++;
        if (log_stall[30] !== 16'd7) begin
            bad++;
            $display("FAIL div_stall: stall=%0d, want 7", log_stall[30]);
        end
    endtask

    // Flush a held instruction blocked on a pending x3 write.
    task automatic test_flush;
        int late;
        do_reset();
        q.delete();
        q.push_back('{4, 4'b0000, 5'd3, 5'd1, 5'd2, 1'b1});
        q.push_back('{4, 4'b0000, 5'd9, 5'd3, 5'd0, 1'b1});
        run_seq(15, 6);
        late = 0;
        for (int k = 6; k < 15; k++) if (log_ex[k] === 1'b1) late++;
        total++;
        if (late != 0 || log_rdy[6] !== 1'b0 || log_rdy[7] !== 1'b1) begin
            bad++;
            $display("FAIL flush_drop: late_issues=%0d rdy6=%b rdy7=%b, want 0/0/1", late, log_rdy[6], log_rdy[7]);
        end
        total++;
        if (log_wb[6] !== 1'b1 || log_wb_rd[6] !== 5'd3 || log_busy[6] !== 32'h8 || log_busy[7] !== 32'h0) begin
            bad++;
            $display("FAIL flush_inflight: wb=%b rd=%0d busy6=%h busy7=%h, want 1/3/00000008/0", log_wb[6], log_wb_rd[6], log_busy[6], log_busy[7]);
        end
        total++;
        if (log_stall[14] !== 16'd0) begin
            bad++;
            $display("FAIL flush_stall: stall=%0d, want 0", log_stall[14]);
        end
    endtask

    // Reset while a div and a mul are in flight.
    task automatic test_reset_mid;
        int ghosts;
        do_reset();
        q.delete();
        q.push_back('{1, 4'b0100, 5'd7, 5'd1, 5'd2, 1'b1});
        q.push_back('{1, 4'b0011, 5'd5, 5'd1, 5'd2, 1'b1});
        run_seq(5, -1);
        total++;
        if (log_busy[4] !== 32'hA0) begin
            bad++;
            $display("FAIL rmid_before: busy=%h, want 000000a0", log_busy[4]);
        end
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        #1;
        total++;
        if (bus.busy_vec !== 32'h0 || bus.wb_valid !== 1'b0 || bus.dec_ready !== 1'b1) begin
            bad++;
            $display("FAIL rmid_async: busy=%h wb=%b rdy=%b, want 0/0/1", bus.busy_vec, bus.wb_valid, bus.dec_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        q.delete();
        run_seq(14, -1);
        ghosts = 0;
        for (int k = 0; k < 14; k++) if (log_wb[k] !== 1'b0 || log_busy[k] !== 32'h0) ghosts++;
        total++;
        if (ghosts != 0) begin
            bad++;
            $display("FAIL rmid_after: %0d cycles with wb/busy activity, want 0", ghosts);
        end
    endtask

    // Random traffic against the absolute-time model.
    task automatic test_random;
        bit         m_hv;
        logic [3:0] h_op;
        int         h_rd, h_rs1, h_rs2;
        bit         h_rw;
        int         m_stall;
        int         lat;
        bit         iss, exp_rdy, exp_wb;
        int         exp_wb_rd;
        logic [31:0] exp_busy;
        int         sel;
        do_reset();
        m_hv = 0;
        h_op = '0; h_rd = 0; h_rs1 = 0; h_rs2 = 0; h_rw = 0;
        m_stall = 0;
        m_div_free = 0;
        m_wb_at.delete();
        for (int r = 0; r < 32; r++) begin
            m_free_at[r] = 0;
            m_busy_from[r] = 0;
        end
        for (int c = 0; c < 900; c++) begin
            @(negedge clk);
            bus.dec_valid = ($urandom_range(0, 3) != 0);
            bus.flush = ($urandom_range(0, 15) == 0);
            sel = int'($urandom_range(0, 9));
            if (sel < 3) bus.dec_alu_op = 4'b0011;
            else if (sel == 3) bus.dec_alu_op = 4'b0100;
            else bus.dec_alu_op = 4'($urandom_range(0, 15));
            bus.dec_rd = 5'($urandom_range(0, 7));
            bus.dec_rs1 = 5'($urandom_range(0, 7));
            bus.dec_rs2 = 5'($urandom_range(0, 7));
            bus.dec_reg_write = ($urandom_range(0, 4) != 0);
            #1;
            lat = (h_op == 4'b0011) ? 3 : (h_op == 4'b0100) ? 8 : 1;
            iss = m_hv && !bus.flush
                && c >= m_free_at[h_rs1] && c >= m_free_at[h_rs2]
                && (!(h_rw && h_rd != 0) || c >= m_free_at[h_rd])
                && (!h_rw || !m_wb_at.exists(c + lat))
                && (h_op != 4'b0100 || c >= m_div_free);
            exp_rdy = !bus.flush && (!m_hv || iss);
            exp_wb = m_wb_at.exists(c);
            exp_wb_rd = exp_wb ? m_wb_at[c] : 0;
            for (int r = 0; r < 32; r++) exp_busy[r] = (m_busy_from[r] <= c) && (c < m_free_at[r]);
            total++;
            if (bus.dec_ready !== exp_rdy || bus.ex_valid !== iss) begin
                bad++;
                $display("FAIL rnd_hs c=%0d: ready=%b ex=%b, want %b %b", c, bus.dec_ready, bus.ex_valid, exp_rdy, iss);
            end
            if (iss) begin
                total++;
                if ({bus.ex_alu_op, bus.ex_rd, bus.ex_rs1, bus.ex_rs2} !== {h_op, 5'(h_rd), 5'(h_rs1), 5'(h_rs2)}) begin
                    bad++;
                    $display("FAIL rnd_fields c=%0d: op=%h rd=%0d rs=%0d,%0d want %h %0d %0d,%0d", c, bus.ex_alu_op, bus.ex_rd, bus.ex_rs1, bus.ex_rs2, h_op, h_rd, h_rs1, h_rs2);
                end
            end
            total++;
            if (bus.wb_valid !== exp_wb || (exp_wb && bus.wb_rd !== 5'(exp_wb_rd))) begin
                bad++;
                $display("FAIL rnd_wb c=%0d: wb=%b rd=%0d, want %b %0d", c, bus.wb_valid, bus.wb_rd, exp_wb, exp_wb_rd);
            end
            total++;
            if (bus.busy_vec !== exp_busy || bus.stall_cnt !== 16'(m_stall)) begin
                bad++;
                $display("FAIL rnd_state c=%0d: busy=%h stall=%0d, want %h %0d", c, bus.busy_vec, bus.stall_cnt, exp_busy, m_stall);
            end
            if (iss) begin
                if (h_rw) begin
                    m_wb_at[c + lat] = h_rd;
                    if (h_rd != 0) begin
                        m_busy_from[h_rd] = c + 1;
                        m_free_at[h_rd] = c + lat + 1;
                    end
                end
                if (h_op == 4'b0100) m_div_free = c + 8;
            end
            if (m_hv && !iss && !bus.flush && m_stall < 65535) m_stall++;
            if (bus.dec_valid && exp_rdy) begin
                m_hv = 1;
                h_op = bus.dec_alu_op;
                h_rd = int'(bus.dec_rd);
                h_rs1 = int'(bus.dec_rs1);
                h_rs2 = int'(bus.dec_rs2);
                h_rw = bus.dec_reg_write;
            end else if (iss || bus.flush) begin
                m_hv = 0;
            end
            if (exp_wb) m_wb_at.delete(c);
        end
    endtask

    initial begin
        test_reset();
        test_raw();
        test_mul_indep();
        test_wb_collision();
        test_div();
        test_flush();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
